transmissor_snooping_mesi: RTL and testbench

TRANSMISSOR_SNOOPING_MESI -- requirements
Module: transmissor_snooping_mesi

---
 rtl/transmissor_snooping_mesi.sv | 131 +++++++++++++
 tb/tb_transmissor_snooping_mesi.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/transmissor_snooping_mesi.sv
// MESI-style snooping transmitter for one cache line: classifies CPU accesses, arbitrates for the
// bus, performs write-back and miss/invalidate messages, and tracks the line state.
module transmissor_snooping_mesi #(
    parameter logic [1:0] EXCLUSIVE = 2'b10,
    parameter logic [1:0] SHARED    = 2'b01,
    parameter logic [1:0] INVALID   = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_op,
    input  logic       hit,
    input  logic       snoop_valid,
    input  logic [1:0] snoop_estado,
    input  logic       bus_grant,
    input  logic       bus_done,
    output logic       bus_req,
    output logic [1:0] bus,
    output logic       wb,
    output logic [1:0] estado,
    output logic       cpu_ready
);

    localparam logic [1:0] MsgNone       = 2'b00;
    localparam logic [1:0] MsgReadMiss   = 2'b01;
    localparam logic [1:0] MsgWriteMiss  = 2'b10;
    localparam logic [1:0] MsgInvalidate = 2'b11;

    typedef enum logic [2:0] {StIdle, StArb, StWb, StBusop, StResp} state_e;

    state_e     state_q;
    logic [1:0] msg_q;
    logic [1:0] final_q;
    logic       wb_pend_q;

    logic       read_hit;
    logic       write_hit;
    logic       upgrade;
    logic [1:0] arb_msg;
    logic       arb_wb;

    assign read_hit  = !cpu_op && hit && (estado != INVALID);
    assign write_hit = cpu_op && hit && (estado == EXCLUSIVE);
    assign upgrade   = cpu_op && hit && (estado == SHARED);

    // Pending message and write-back as seen after this cycle's snoop update in ARB; a grant in
    // the same cycle acts on these post-snoop values.
    assign arb_msg = (snoop_valid && (snoop_estado == INVALID) && (msg_q == MsgInvalidate))
                     ? MsgWriteMiss : msg_q;
    assign arb_wb  = wb_pend_q && !(snoop_valid && (snoop_estado != EXCLUSIVE));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            estado    <= INVALID;
            bus_req   <= 1'b0;
            bus       <= MsgNone;
            wb        <= 1'b0;
            cpu_ready <= 1'b0;
            msg_q     <= MsgNone;
            final_q   <= INVALID;
            wb_pend_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (snoop_valid) begin
                        estado <= snoop_estado;
                    end else if (cpu_req) begin
                        if (read_hit || write_hit) begin
                            state_q   <= StResp;
                            cpu_ready <= 1'b1;
                        end else begin
                            state_q   <= StArb;
                            bus_req   <= 1'b1;
                            final_q   <= cpu_op ? EXCLUSIVE : SHARED;
                            // A dirty line can only reach here on a tag miss.
                            wb_pend_q <= (estado == EXCLUSIVE);
                            msg_q     <= upgrade ? MsgInvalidate
                                                 : (cpu_op ? MsgWriteMiss : MsgReadMiss);
                        end
                    end
                end
                StArb: begin
                    if (snoop_valid) begin
                        estado <= snoop_estado;
                    end
                    msg_q     <= arb_msg;
                    wb_pend_q <= arb_wb;
                    if (bus_grant) begin
                        if (arb_wb) begin
                            state_q <= StWb;
                            wb      <= 1'b1;
                        end else begin
                            state_q <= StBusop;
                            bus     <= arb_msg;
                        end
                    end
                end
                StWb: begin
                    if (bus_done) begin
                        state_q <= StBusop;
                        estado  <= INVALID;
                        wb      <= 1'b0;
                        bus     <= msg_q;
                    end
                end
                StBusop: begin
                    if (bus_done) begin
                        state_q   <= StResp;
                        estado    <= final_q;
                        bus       <= MsgNone;
                        bus_req   <= 1'b0;
                        cpu_ready <= 1'b1;
                    end
                end
                StResp: begin
                    state_q   <= StIdle;
                    cpu_ready <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    bus_req   <= 1'b0;
                    bus       <= MsgNone;
                    wb        <= 1'b0;
                    cpu_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmissor_snooping_mesi.sv
// Randomized bench for transmissor_snooping_mesi: the bench acts as CPU, arbiter and snoop
// receiver, and compares each transaction with a transaction-level MESI model.
module tb_transmissor_snooping_mesi;

    localparam logic [1:0] EXC = 2'b10;
    localparam logic [1:0] SHR = 2'b01;
    localparam logic [1:0] INV = 2'b00;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req;
    logic       cpu_op;
    logic       hit;
    logic       snoop_valid;
    logic [1:0] snoop_estado;
    logic       bus_grant;
    logic       bus_done;
    logic       bus_req;
    logic [1:0] bus;
    logic       wb;
    logic [1:0] estado;
    logic       cpu_ready;

    int total = 0;
    int bad   = 0;

    transmissor_snooping_mesi dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_op      (cpu_op),
        .hit         (hit),
        .snoop_valid (snoop_valid),
        .snoop_estado(snoop_estado),
        .bus_grant   (bus_grant),
        .bus_done    (bus_done),
        .bus_req     (bus_req),
        .bus         (bus),
        .wb          (wb),
        .estado      (estado),
        .cpu_ready   (cpu_ready)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction outcome from the coherence rules: whether the bus is used, whether a
    // write-back precedes the message, which message goes out, and the final line state.
    function automatic void model(input logic op, input logic h, input logic [1:0] s0,
                                  input bit arb_snp, input logic [1:0] sv,
                                  output bit uses_bus, output bit do_wb,
                                  output logic [1:0] msg, output logic [1:0] fin);
        if ((!op && h && s0 != INV) || (op && h && s0 == EXC)) begin
            uses_bus = 1'b0;
            do_wb    = 1'b0;
            msg      = 2'd0;
            fin      = s0;
            return;
        end
        uses_bus = 1'b1;
        fin      = op ? EXC : SHR;
        do_wb    = (s0 == EXC);
        msg      = !op ? 2'd1 : ((h && s0 == SHR) ? 2'd3 : 2'd2);
        if (arb_snp) begin
            if (msg == 2'd3 && sv == INV) msg = 2'd2;
            if (sv != EXC) do_wb = 1'b0;
        end
    endfunction

    task automatic run_txn(input logic op, input logic h, input logic [1:0] s0, input bit simul,
                           input bit arb_snp, input logic [1:0] snp_val, input int gdly,
                           input int ddly, input bit done_w_grant);
        bit         e_bus, e_wb, seen_req, seen_wb;
        logic [1:0] e_msg, e_fin, seen_msg;
        int         ready_cnt, ready_at, arb_cyc, wb_cyc, op_cyc;
        model(op, h, s0, arb_snp, snp_val, e_bus, e_wb, e_msg, e_fin);
        seen_req = 0; seen_wb = 0; seen_msg = 2'd0;
        ready_cnt = 0; ready_at = 0; arb_cyc = 0; wb_cyc = 0; op_cyc = 0;
        @(negedge clock);
        snoop_valid = 1'b1; snoop_estado = s0; cpu_req = simul; cpu_op = op; hit = h;
        @(negedge clock);
        check_eq("idle_snoop_estado", estado, s0);
        check_eq("idle_snoop_prio", {cpu_ready, bus_req}, 0);
        snoop_valid = 1'b0; cpu_req = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            bus_grant = 1'b0; bus_done = 1'b0; snoop_valid = 1'b0;
            if (bus_req) seen_req = 1'b1;
            if (wb) begin
                seen_wb = 1'b1;
                wb_cyc++;
                if (wb_cyc == 1) begin
                    snoop_valid = 1'b1; snoop_estado = 2'($urandom_range(0, 2));
                end
                if (wb_cyc == ddly + 1) bus_done = 1'b1;
            end else if (bus_req && bus == 2'd0) begin
                arb_cyc++;
                if (arb_cyc == 1 && arb_snp) begin
                    snoop_valid = 1'b1; snoop_estado = snp_val;
                end
                if (arb_cyc == gdly + 1) begin
                    bus_grant = 1'b1; bus_done = done_w_grant;
                end
            end else if (bus_req) begin
                seen_msg = bus;
                op_cyc++;
                if (op_cyc == 1) begin
                    snoop_valid = 1'b1; snoop_estado = 2'($urandom_range(0, 2));
                end
                if (op_cyc == ddly + 1) bus_done = 1'b1;
            end
            if (cpu_ready) begin
                ready_cnt++;
                if (ready_cnt == 1) begin
                    ready_at = n;
                    check_eq("resp_outputs_quiet", {bus_req, wb, bus}, 0);
                end
                cpu_req = 1'b0;
            end
            if (ready_cnt > 0 && n > ready_at) break;
        end
        check_eq("ready_pulses", ready_cnt, 1);
        check_eq("bus_used", seen_req, e_bus);
        check_eq("writeback", seen_wb, e_wb);
        check_eq("bus_msg", seen_msg, e_msg);
        check_eq("final_estado", estado, e_fin);
        if (!e_bus) check_eq("hit_latency", ready_at, 1);
        if (ready_cnt == 0) begin
            cpu_req = 1'b0; bus_grant = 1'b0; bus_done = 1'b0; snoop_valid = 1'b0;
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
    endtask

    // Phase 0 = ARB, 1 = WB, 2 = BUSOP; reset lands together with every other input active.
    task automatic reset_during(input int phase);
        bit reached;
        reached = 1'b0;
        @(negedge clock);
        snoop_valid = 1'b1; snoop_estado = EXC; cpu_req = 1'b0;
        @(negedge clock);
        snoop_valid = 1'b0; cpu_req = 1'b1; cpu_op = 1'b0; hit = 1'b0;
        for (int n = 0; n < 30 && !reached; n++) begin
            @(negedge clock);
            bus_grant = 1'b0; bus_done = 1'b0;
            if ((phase == 0 && bus_req && !wb && bus == 2'd0) || (phase == 1 && wb) ||
                (phase == 2 && bus != 2'd0)) begin
                reached = 1'b1;
                reset = 1'b1; bus_grant = 1'b1; bus_done = 1'b1;
                snoop_valid = 1'b1; snoop_estado = SHR;
            end else if (bus_req && !wb && bus == 2'd0) begin
                bus_grant = 1'b1;
            end else if (wb || bus != 2'd0) begin
                bus_done = 1'b1;
            end
        end
        check_eq("rst_phase_reached", reached, 1);
        reset = 1'b1;
        @(negedge clock);
        check_eq("rst_bus", bus, 0);
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_wb", wb, 0);
        check_eq("rst_estado", estado, INV);
        check_eq("rst_cpu_ready", cpu_ready, 0);
        reset = 1'b0; cpu_req = 1'b0; bus_grant = 1'b0; bus_done = 1'b0; snoop_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_eq("rst_no_activity", {cpu_ready, bus_req}, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_op = 1'b0; hit = 1'b0; snoop_valid = 1'b0;
        snoop_estado = 2'd0; bus_grant = 1'b0; bus_done = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("reset_estado", estado, INV);
        check_eq("reset_bus_req", bus_req, 0);
        check_eq("reset_bus", bus, 0);
        check_eq("reset_wb", wb, 0);
        check_eq("reset_cpu_ready", cpu_ready, 0);
        reset = 1'b0;

        run_txn(1'b0, 1'b1, SHR, 1'b0, 1'b0, INV, 1, 1, 1'b0);  // shared read hit
        run_txn(1'b1, 1'b1, SHR, 1'b0, 1'b0, INV, 3, 2, 1'b0);  // upgrade -> invalidate
        run_txn(1'b0, 1'b0, EXC, 1'b0, 1'b0, INV, 1, 2, 1'b0);  // dirty read miss -> WB
        run_txn(1'b1, 1'b1, SHR, 1'b0, 1'b1, INV, 2, 1, 1'b0);  // invalidate -> writeMiss
        run_txn(1'b0, 1'b1, EXC, 1'b1, 1'b0, INV, 0, 0, 1'b0);  // snoop and request together
        run_txn(1'b1, 1'b0, SHR, 1'b0, 1'b0, INV, 0, 0, 1'b1);  // done alongside grant
        run_txn(1'b1, 1'b0, EXC, 1'b0, 1'b1, SHR, 0, 1, 1'b0);  // WB cancelled by snoop
        reset_during(0);
        reset_during(1);
        reset_during(2);

        for (int i = 0; i < 150; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
